// File: rtl/dircc_rx_mailbox_pkg.sv
// Shared constants for the DiRCC receive mailbox writer.
//   - CSR word indices and STATUS/CTRL bit positions
//   - receive FSM state encoding
//   - slot header bit positions
//   - saturating 8-bit increment used by the drop counter
package dircc_rx_mailbox_pkg;

   localparam logic [1:0] CSR_STATUS = 2'd0;
   localparam logic [1:0] CSR_HEAD   = 2'd1;
   localparam logic [1:0] CSR_TAIL   = 2'd2;
   localparam logic [1:0] CSR_CTRL   = 2'd3;

   localparam int unsigned STATUS_COUNT_LSB = 0;
   localparam int unsigned STATUS_FULL_BIT  = 9;
   localparam int unsigned STATUS_OVF_BIT   = 10;
   localparam int unsigned STATUS_DROP_LSB  = 16;

   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_IRQEN_BIT = 1;
   localparam int unsigned CTRL_CLR_BIT   = 8;

   localparam int unsigned HDR_TRUNC_BIT = 15;
   localparam int unsigned HDR_LEN_W     = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      LENGTH  = 2'd2,
      PUBLISH = 2'd3
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/dircc_node_rx_mailbox_writer_if.sv
// Signal bundle of the receive mailbox writer.
//   rx_*   : inbound 16-bit message stream (valid/ready, sop/eop)
//   mem_*  : processing memory second port (s2), write-only use
//   csr_*  : CSR slave towards the Nios core
//   irq    : level interrupt
// slave is the mailbox writer's view; master is the surrounding system's view.
interface dircc_node_rx_mailbox_writer_if;

   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_startofpacket;
   logic        rx_endofpacket;
   logic        rx_ready;

   logic [14:0] mem_address2;
   logic [15:0] mem_writedata2;
   logic [1:0]  mem_byteenable2;
   logic        mem_chipselect2;
   logic        mem_write2;
   logic        mem_clken2;

   logic [1:0]  csr_address;
   logic        csr_read;
   logic        csr_write;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
   logic        irq;

   modport slave (
      input  rx_data, rx_valid, rx_startofpacket, rx_endofpacket,
      output rx_ready,
      output mem_address2, mem_writedata2, mem_byteenable2, mem_chipselect2,
      output mem_write2, mem_clken2,
      input  csr_address, csr_read, csr_write, csr_writedata,
      output csr_readdata, irq
   );

   modport master (
      output rx_data, rx_valid, rx_startofpacket, rx_endofpacket,
      input  rx_ready,
      input  mem_address2, mem_writedata2, mem_byteenable2, mem_chipselect2,
      input  mem_write2, mem_clken2,
      output csr_address, csr_read, csr_write, csr_writedata,
      input  csr_readdata, irq
   );

endinterface

// File: rtl/dircc_rx_slot_ring.sv
// Head/tail/count bookkeeping for the circular slot ring.
//   clk, reset  : clock, synchronous active-high reset
//   publish     : one completed slot becomes visible (head advances)
//   pop         : consumer releases one slot (ignored when empty)
//   head, tail  : slot indices, wrap modulo NUM_SLOTS
//   count       : occupied slots, 0..NUM_SLOTS
//   full, empty : count flags
module dircc_rx_slot_ring #(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             publish,
   input  logic             pop,
   output logic [IDX_W-1:0] head,
   output logic [IDX_W-1:0] tail,
   output logic [IDX_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             do_pop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == (IDX_W+1)'(NUM_SLOTS));
   assign do_pop = pop & ~empty;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (publish) head_d = head_q + IDX_W'(1);
      if (do_pop)  tail_d = tail_q + IDX_W'(1);
      // Simultaneous publish and pop leave the occupancy unchanged.
      case ({publish, do_pop})
         2'b10:   count_d = count_q + (IDX_W+1)'(1);
         2'b01:   count_d = count_q - (IDX_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head  = head_q;
   assign tail  = tail_q;
   assign count = count_q;

endmodule

// File: rtl/dircc_node_rx_mailbox_writer.sv
// Receive mailbox writer: stores inbound messages into a ring of fixed-size slots in processing
// memory (s2 port) and publishes completed slots to the Nios through a CSR slave and level irq.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave view of the stream, s2 and CSR signal bundle
// Slot word 0 holds the header {truncated, stored_len}; payload occupies words 1..SLOT_WORDS-1.
module dircc_node_rx_mailbox_writer
   import dircc_rx_mailbox_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 18432,
   parameter int unsigned SLOT_WORDS = 256,
   parameter int unsigned NUM_SLOTS  = 8
) (
   input logic                          clk,
   input logic                          reset,
   dircc_node_rx_mailbox_writer_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
   localparam logic [HDR_LEN_W-1:0] MAX_LEN = HDR_LEN_W'(SLOT_WORDS - 1);

   if ((BASE_ADDR + NUM_SLOTS * SLOT_WORDS > 20480) ||
       (SLOT_WORDS < 4) || (SLOT_WORDS > 32768) || ((SLOT_WORDS & (SLOT_WORDS - 1)) != 0) ||
       (NUM_SLOTS < 2) || (NUM_SLOTS > 256) || ((NUM_SLOTS & (NUM_SLOTS - 1)) != 0))
   begin : gen_cfg_err
      $error("dircc_node_rx_mailbox_writer: invalid slot ring configuration");
   end

   state_t                 state_q, state_d;
   logic [HDR_LEN_W-1:0]   len_q, len_d;
   logic                   trunc_q, trunc_d;
   logic [14:0]            mem_addr_q, mem_addr_d;
   logic [15:0]            mem_data_q, mem_data_d;
   logic                   mem_wr_q, mem_wr_d;
   logic [7:0]             drop_q, drop_d;
   logic                   ovf_q, ovf_d;
   logic                   enable_q, enable_d, irq_en_q, irq_en_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   irq_q, irq_d;

   logic                   rx_ready_c, accept, drop_ev, ovf_ev, publish, pop, ctrl_wr, clr;
   logic [IDX_W-1:0]       head, tail;
   logic [IDX_W:0]         count;
   logic                   full, empty;
   logic [14:0]            slot_base;
   logic                   unused_wdata;

   dircc_rx_slot_ring #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_ring (
      .clk     (clk),
      .reset   (reset),
      .publish (publish),
      .pop     (pop),
      .head    (head),
      .tail    (tail),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // head only moves in PUBLISH, so the base is stable for the whole message.
   assign slot_base = 15'(BASE_ADDR + int'(head) * SLOT_WORDS);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      trunc_d    = trunc_q;
      mem_wr_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      rx_ready_c = 1'b0;
      accept     = 1'b0;
      drop_ev    = 1'b0;
      ovf_ev     = 1'b0;
      publish    = 1'b0;
      unique case (state_q)
         IDLE: begin
            rx_ready_c = enable_q & ~full;
            accept     = bus.rx_valid & rx_ready_c;
            if (accept) begin
               if (bus.rx_startofpacket) begin
                  mem_wr_d   = 1'b1;
                  mem_addr_d = slot_base + 15'd1;
                  mem_data_d = bus.rx_data;
                  len_d      = HDR_LEN_W'(1);
                  trunc_d    = 1'b0;
                  state_d    = bus.rx_endofpacket ? LENGTH : PAYLOAD;
               end else begin
                  drop_ev = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            rx_ready_c = 1'b1;
            accept     = bus.rx_valid;
            if (accept) begin
               if (bus.rx_startofpacket) begin
                  // A new sop closes the current message; the sop halfword itself is lost.
                  drop_ev = 1'b1;
                  state_d = LENGTH;
               end else begin
                  if (len_q < MAX_LEN) begin
                     mem_wr_d   = 1'b1;
                     mem_addr_d = slot_base + len_q + 15'd1;
                     mem_data_d = bus.rx_data;
                     len_d      = len_q + HDR_LEN_W'(1);
                  end else begin
                     trunc_d = 1'b1;
                  end
                  if (bus.rx_endofpacket) state_d = LENGTH;
               end
            end
         end
         LENGTH: begin
            mem_wr_d   = 1'b1;
            mem_addr_d = slot_base;
            mem_data_d = {trunc_q, len_q};
            ovf_ev     = trunc_q;
            state_d    = PUBLISH;
         end
         PUBLISH: begin
            publish = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop      = bus.csr_write & (bus.csr_address == CSR_TAIL);
      ctrl_wr  = bus.csr_write & (bus.csr_address == CSR_CTRL);
      clr      = ctrl_wr & bus.csr_writedata[CTRL_CLR_BIT];
      enable_d = ctrl_wr ? bus.csr_writedata[CTRL_EN_BIT] : enable_q;
      irq_en_d = ctrl_wr ? bus.csr_writedata[CTRL_IRQEN_BIT] : irq_en_q;
      // Clear first so an event in the same cycle is not lost.
      drop_d = clr ? 8'd0 : drop_q;
      if (drop_ev) drop_d = sat_inc8(drop_d);
      ovf_d = clr ? 1'b0 : ovf_q;
      if (ovf_ev) ovf_d = 1'b1;
      rdata_d = rdata_q;
      if (bus.csr_read) begin
         rdata_d = '0;
         unique case (bus.csr_address)
            CSR_STATUS: begin
               rdata_d[STATUS_COUNT_LSB +: 9] = 9'(count);
               rdata_d[STATUS_FULL_BIT]       = full;
               rdata_d[STATUS_OVF_BIT]        = ovf_q;
               rdata_d[STATUS_DROP_LSB +: 8]  = drop_q;
            end
            CSR_HEAD: rdata_d[IDX_W-1:0] = head;
            CSR_TAIL: rdata_d[IDX_W-1:0] = tail;
            CSR_CTRL: begin
               rdata_d[CTRL_EN_BIT]    = enable_q;
               rdata_d[CTRL_IRQEN_BIT] = irq_en_q;
            end
         endcase
      end
      irq_d = irq_en_q & ~empty;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         trunc_q    <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_wr_q   <= 1'b0;
         drop_q     <= '0;
         ovf_q      <= 1'b0;
         enable_q   <= 1'b0;
         irq_en_q   <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         trunc_q    <= trunc_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_wr_q   <= mem_wr_d;
         drop_q     <= drop_d;
         ovf_q      <= ovf_d;
         enable_q   <= enable_d;
         irq_en_q   <= irq_en_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.rx_ready        = rx_ready_c;
   assign bus.mem_address2    = mem_addr_q;
   assign bus.mem_writedata2  = mem_data_q;
   assign bus.mem_write2      = mem_wr_q;
   assign bus.mem_chipselect2 = mem_wr_q;
   assign bus.mem_byteenable2 = 2'b11;
   assign bus.mem_clken2      = 1'b1;
   assign bus.csr_readdata    = rdata_q;
   assign bus.irq             = irq_q;

   assign unused_wdata = ^{bus.csr_writedata[31:9], bus.csr_writedata[7:2]};

endmodule
